generic_bus_arbiter: RTL and testbench

GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

---
 rtl/generic_bus_arbiter_if.sv | 25 ++
 rtl/generic_bus_arbiter.sv | 111 +++++++++++
 tb/tb_generic_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_bus_arbiter_if.sv
// Simple memory bus: the requestor drives addr/data/strobes and the responder
// answers with rdata plus a busy flag that drops for one cycle on completion.
interface generic_bus_if #(
    parameter int RAM_ADDR_SIZE = 32
);
    logic [RAM_ADDR_SIZE-1:0] addr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ren;
    logic                     wen;
    logic                     busy;
    logic [3:0]               byte_en;

    // Responder view: what an arbiter or memory sees of an upstream master.
    modport generic_bus (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy
    );

    // Master view: what drives a downstream memory.
    modport cpu (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy
    );
endinterface

// File: rtl/generic_bus_arbiter.sv
// Two-master arbiter (instruction and data side) onto one memory port with
// alternating priority under contention and a mandatory idle cycle per grant.
module generic_bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input logic                CLK,
    input logic                nRST,
    generic_bus_if.generic_bus ibus,
    generic_bus_if.generic_bus dbus,
    generic_bus_if.cpu         out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    // The side recorded as "last served" at reset is the one that must lose
    // the first contention.
    localparam side_t RESET_LAST = DATA_FIRST ? SIDE_I : SIDE_D;

    state_t state;
    side_t  last_served;
    logic   ireq;
    logic   dreq;

    assign ireq = ibus.ren | ibus.wen;
    assign dreq = dbus.ren | dbus.wen;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            last_served <= RESET_LAST;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq && dreq) begin
                        state <= (last_served == SIDE_D) ? GNT_I : GNT_D;
                    end else if (dreq) begin
                        state <= GNT_D;
                    end else if (ireq) begin
                        state <= GNT_I;
                    end
                end
                GNT_I: begin
                    // A dropped request is an abort and does not count as service.
                    if (!ireq) begin
                        state <= IDLE;
                    end else if (!out.busy) begin
                        state       <= IDLE;
                        last_served <= SIDE_I;
                    end
                end
                GNT_D: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (!out.busy) begin
                        state       <= IDLE;
                        last_served <= SIDE_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The downstream port is a pure mux of the granted requestor so a
    // request launched on the grant edge can complete in that same cycle.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        out.addr    = '0;
        out.wdata   = '0;
        out.byte_en = '0;
        out.ren     = 1'b0;
        out.wen     = 1'b0;
        ibus.busy   = 1'b1;
        dbus.busy   = 1'b1;
        case (state)
            GNT_I: begin
                out.addr    = ibus.addr;
                out.wdata   = ibus.wdata;
                out.byte_en = ibus.byte_en;
                out.ren     = ibus.ren;
                out.wen     = ibus.wen;
                ibus.busy   = out.busy | ~ireq;
            end
            GNT_D: begin
                out.addr    = dbus.addr;
                out.wdata   = dbus.wdata;
                out.byte_en = dbus.byte_en;
                out.ren     = dbus.ren;
                out.wen     = dbus.wen;
                dbus.busy   = out.busy | ~dreq;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the granted side's busy=0 qualifies it.
    assign ibus.rdata = out.rdata;
    assign dbus.rdata = out.rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Self-checking bench: two arbiters (DATA_FIRST=1 and 0) driven by directed
// scenarios then random traffic, compared every cycle to a transaction model.
module tb_generic_bus_arbiter;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    localparam int I = 0;
    localparam int D = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    req_t        rq       [2][2];
    logic        mem_busy [2];
    logic [31:0] mem_rdata[2];
    req_t        oq       [2];
    logic        busy_o   [2][2];
    logic [31:0] rdata_o  [2][2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance 0 has DATA_FIRST=1, instance 1 has DATA_FIRST=0.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        generic_bus_if ib ();
        generic_bus_if db ();
        generic_bus_if ob ();

        assign ib.ren     = rq[g][I].ren;
        assign ib.wen     = rq[g][I].wen;
        assign ib.addr    = rq[g][I].addr;
        assign ib.wdata   = rq[g][I].wdata;
        assign ib.byte_en = rq[g][I].be;
        assign db.ren     = rq[g][D].ren;
        assign db.wen     = rq[g][D].wen;
        assign db.addr    = rq[g][D].addr;
        assign db.wdata   = rq[g][D].wdata;
        assign db.byte_en = rq[g][D].be;
        assign ob.busy    = mem_busy[g];
        assign ob.rdata   = mem_rdata[g];

        assign oq[g]         = {ob.ren, ob.wen, ob.addr, ob.wdata, ob.byte_en};
        assign busy_o[g][I]  = ib.busy;
        assign busy_o[g][D]  = db.busy;
        assign rdata_o[g][I] = ib.rdata;
        assign rdata_o[g][D] = db.rdata;

        generic_bus_arbiter #(.DATA_FIRST(g == 0)) u_dut (
            .CLK  (clk),
            .nRST (rst_n),
            .ibus (ib),
            .dbus (db),
            .out  (ob)
        );
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic active(input req_t r);
        return r.ren | r.wen;
    endfunction

    // Reference model: which side (if any) currently owns the port, who was
    // served last, and which side completed on the most recent edge.
    int gnt  [2] = '{-1, -1};
    int last [2] = '{I, D};
    bit done [2][2];
    bit chk_en = 1'b0;
    int df   [2] = '{1, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            done[k][I] = 1'b0;
            done[k][D] = 1'b0;
            if (!rst_n) begin
                gnt[k]  = -1;
                last[k] = (df[k] != 0) ? I : D;
            end else if (gnt[k] < 0) begin
                if (active(rq[k][I]) && active(rq[k][D])) gnt[k] = 1 - last[k];
                else if (active(rq[k][D]))                gnt[k] = D;
                else if (active(rq[k][I]))                gnt[k] = I;
            end else if (!active(rq[k][gnt[k]])) begin
                gnt[k] = -1;
            end else if (!mem_busy[k]) begin
                done[k][gnt[k]] = 1'b1;
                last[k] = gnt[k];
                gnt[k]  = -1;
            end
        end
        if (!rst_n) chk_en = 1'b1;
    end

    function automatic logic [135:0] expect_vec(input int k);
        req_t o;
        logic bi;
        logic bd;
        o  = '0;
        bi = 1'b1;
        bd = 1'b1;
        if (gnt[k] >= 0) begin
            o = rq[k][gnt[k]];
            if (gnt[k] == I) bi = active(o) ? mem_busy[k] : 1'b1;
            else             bd = active(o) ? mem_busy[k] : 1'b1;
        end
        return {o, bi, bd, mem_rdata[k], mem_rdata[k]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cycle_dut%0d", k),
                      {oq[k], busy_o[k][I], busy_o[k][D], rdata_o[k][I], rdata_o[k][D]},
                      expect_vec(k));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int s, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        for (int k = 0; k < 2; k++) rq[k][s] = {ren, wen, addr, wdata, be};
    endtask

    task automatic set_mem(input logic b, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            mem_busy[k]  = b;
            mem_rdata[k] = d;
        end
    endtask

    task automatic clear_reqs();
        set_req(I, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic new_txn(input int k, input int s);
        int kind;
        kind = $urandom_range(0, 3);
        rq[k][s] = {(kind != 1), (kind == 1 || kind == 3), $urandom(), $urandom(), 4'($urandom())};
    endtask

    int cnt;
    bit zero_wait;

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        set_mem(1'b1, 32'h0);
        tick();
        // Requests present during reset must not leak to the memory port.
        set_req(D, 1'b1, 1'b1, 32'hFFF, 32'h5555_AAAA, 4'hF);
        tick();
        settle();
        check("reset_out_zero", oq[0], '0);
        check("reset_busy", {busy_o[0][I], busy_o[0][D], busy_o[1][I], busy_o[1][D]}, 4'hF);

        // Both sides request from the first post-reset cycle with zero-wait memory.
        rst_n = 1'b1;
        set_mem(1'b0, 32'hA5A5_0000);
        set_req(I, 1'b1, 1'b0, 32'h0AA0, 32'h0, 4'hF);
        set_req(D, 1'b1, 1'b0, 32'h0DD0, 32'h0, 4'hF);
        for (int j = 1; j <= 12; j++) begin
            tick();
            settle();
            if (j % 2 == 1) begin
                check("alt_dut0", {oq[0].ren, oq[0].addr},
                      {1'b1, ((j % 4) == 1) ? 32'h0DD0 : 32'h0AA0});
                check("alt_dut1", {oq[1].ren, oq[1].addr},
                      {1'b1, ((j % 4) == 1) ? 32'h0AA0 : 32'h0DD0});
                if (j == 1) begin
                    check("first_win_df1", {busy_o[0][I], busy_o[0][D]}, 2'b10);
                    check("first_win_df0", {busy_o[1][I], busy_o[1][D]}, 2'b01);
                end
            end else begin
                check("alt_idle_gap", {oq[0].ren, oq[1].ren, busy_o[0][I], busy_o[0][D]}, 4'b0011);
            end
        end
        clear_reqs();
        tick();
        tick();

        // Single data read with two memory wait states, then an immediate re-request.
        set_mem(1'b1, 32'h0);
        set_req(D, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        settle();
        check("rd_idle_n", oq[0].ren, 1'b0);
        tick();
        settle();
        check("rd_n1", {oq[0].ren, oq[0].addr, busy_o[0][D], busy_o[0][I]}, {1'b1, 32'h100, 2'b11});
        tick();
        settle();
        check("rd_n2", {oq[0].ren, oq[0].addr, busy_o[0][D], busy_o[0][I]}, {1'b1, 32'h100, 2'b11});
        tick();
        set_mem(1'b0, 32'hDEADBEEF);
        settle();
        check("rd_n3", {oq[0].ren, busy_o[0][D], rdata_o[0][D], busy_o[0][I]},
              {1'b1, 1'b0, 32'hDEADBEEF, 1'b1});
        tick();
        set_mem(1'b1, 32'h0);
        set_req(D, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        settle();
        check("rd_mandatory_idle", {oq[0].ren, busy_o[0][D], busy_o[0][I]}, 3'b011);
        tick();
        set_mem(1'b0, 32'h0BADF00D);
        settle();
        check("rd_regrant", {oq[0].ren, oq[0].addr, busy_o[0][D]}, {1'b1, 32'h104, 1'b0});
        tick();
        clear_reqs();
        set_mem(1'b1, 32'h0);
        tick();

        // Zero-wait memory: one instruction fetch every two cycles.
        set_mem(1'b0, 32'h1111_2222);
        set_req(I, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        cnt = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            settle();
            if (busy_o[0][I] == 1'b0) cnt++;
            if (j == 1) check("zw_first_cycle", busy_o[0][I], 1'b0);
        end
        check("zw_throughput", cnt, 5);
        clear_reqs();
        set_mem(1'b1, 32'h0);
        tick();
        tick();

        // Data write aborted mid-wait; the last served side (I) must stay recorded.
        set_req(D, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011);
        tick();
        settle();
        check("wr_grant", {oq[0].ren, oq[0].wen, oq[0].addr, oq[0].wdata, oq[0].be, busy_o[0][D]},
              {2'b01, 32'h200, 32'h12345678, 4'b0011, 1'b1});
        tick();
        set_req(D, 1'b0, 1'b0, 32'h200, 32'h12345678, 4'b0011);
        set_mem(1'b0, 32'h0);
        settle();
        check("abort_no_pulse", {busy_o[0][D], oq[0].wen}, 2'b10);
        tick();
        set_mem(1'b1, 32'h0);
        settle();
        check("abort_idle", {oq[0], busy_o[0][D]}, {70'h0, 1'b1});
        set_req(I, 1'b1, 1'b0, 32'h0AA4, 32'h0, 4'hF);
        set_req(D, 1'b1, 1'b0, 32'h0DD4, 32'h0, 4'hF);
        tick();
        settle();
        check("abort_last_kept", oq[0].addr, 32'h0DD4);
        clear_reqs();
        tick();
        tick();

        // Reset while an instruction read is waiting on memory.
        set_req(I, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        tick();
        settle();
        check("rst_pre", {oq[0].ren, oq[0].addr}, {1'b1, 32'h300});
        rst_n = 1'b0;
        tick();
        settle();
        check("rst_mid_txn", {oq[0].ren, busy_o[0][I], busy_o[0][D]}, 3'b011);
        rst_n = 1'b1;
        clear_reqs();
        tick();
        set_req(D, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF);
        set_mem(1'b0, 32'hCAFEF00D);
        tick();
        settle();
        check("rst_then_d", {oq[0].addr, busy_o[0][D], rdata_o[0][D]}, {32'h304, 1'b0, 32'hCAFEF00D});
        clear_reqs();
        set_mem(1'b1, 32'h0);
        tick();

        // Random traffic: requestors hold until completion or a rare abort.
        zero_wait = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 500 == 0) zero_wait = ~zero_wait;
            rst_n = ($urandom_range(0, 499) != 0);
            for (int k = 0; k < 2; k++) begin
                mem_busy[k]  = zero_wait ? 1'b0 : ($urandom_range(0, 2) != 0);
                mem_rdata[k] = $urandom();
                for (int s = 0; s < 2; s++) begin
                    if (active(rq[k][s])) begin
                        if (done[k][s]) begin
                            if ($urandom_range(0, 1) == 0) new_txn(k, s);
                            else rq[k][s] = '0;
                        end else if ($urandom_range(0, 31) == 0) begin
                            rq[k][s] = '0;
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        new_txn(k, s);
                    end
                end
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
